// File: rtl/sd_sector_store.sv
// Block-RAM stand-in for sd_controller: 512-byte sectors behind the same
// byte-level rd/wr handshake, with SPI-like command latency and byte pacing.
module sd_sector_store #(
    parameter int NUM_SECTORS = 1024,
    parameter int INIT_CYCLES = 64,
    parameter int CMD_LATENCY = 16,
    parameter int BYTE_PERIOD = 8,
    parameter int DIN_DELAY   = 3,
    parameter int TAIL_CYCLES = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic        ready,
    input  logic [31:0] address,
    input  logic        rd,
    output logic [7:0]  dout,
    output logic        byte_available,
    input  logic        wr,
    input  logic [7:0]  din,
    output logic        ready_for_next_byte,
    output logic        err_out
);

    localparam int SW    = (NUM_SECTORS > 1) ? $clog2(NUM_SECTORS) : 1;
    localparam int AW    = SW + 9;
    localparam int CW    = 16;
    localparam int DEPTH = NUM_SECTORS * 512;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RD_BYTES,
        WR_WAIT,
        WR_BYTES,
        WR_COMMIT,
        TAIL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [8:0]    idx;
    logic [SW-1:0] sec;
    logic          oor;
    logic          commit_v;
    logic [8:0]    commit_idx;

    logic [22:0]   req_sector;
    logic          req_oor;
    logic          addr_lo_unused;
    logic          at_din;
    logic          last_byte;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;

    logic [7:0]    mem   [DEPTH];
    logic [7:0]    stage [512];
    logic [7:0]    mem_q1;
    logic [7:0]    mem_q2;
    logic [7:0]    stage_q;

    assign req_sector     = address[31:9];
    assign req_oor        = req_sector >= 23'(NUM_SECTORS);
    assign addr_lo_unused = ^address[8:0];
    assign at_din         = (state == WR_BYTES) && (cnt == CW'(DIN_DELAY));
    assign last_byte      = (idx == 9'd511);
    assign raddr          = {sec, idx};
    assign waddr          = {sec, commit_idx};

    // Staging buffer keeps a half-received sector out of the store.
    always_ff @(posedge clk_in) begin
        if (at_din)
            stage[idx] <= din;
        stage_q <= stage[idx];
    end

    // Two-stage read pipe; idx always points at the byte to emit next.
    always_ff @(posedge clk_in) begin
        if (commit_v && !oor)
            mem[waddr] <= stage_q;
        mem_q1 <= mem[raddr];
        mem_q2 <= mem_q1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state               <= INIT;
            cnt                 <= '0;
            idx                 <= '0;
            sec                 <= '0;
            oor                 <= 1'b0;
            ready               <= 1'b0;
            dout                <= 8'h00;
            byte_available      <= 1'b0;
            ready_for_next_byte <= 1'b0;
            err_out             <= 1'b0;
            commit_v            <= 1'b0;
            commit_idx          <= '0;
        end else begin
            byte_available      <= 1'b0;
            ready_for_next_byte <= 1'b0;
            cnt                 <= cnt + 1'b1;
            commit_v            <= (state == WR_COMMIT);
            commit_idx          <= idx;
            unique case (state)
                INIT: begin
                    if (cnt == CW'(INIT_CYCLES - 1)) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (rd || wr) begin
                        ready <= 1'b0;
                        cnt   <= '0;
                        idx   <= '0;
                        sec   <= req_oor ? '0 : req_sector[SW-1:0];
                        oor   <= req_oor;
                        if (req_oor)
                            err_out <= 1'b1;
                        state <= rd ? RD_WAIT : WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == CW'(CMD_LATENCY - 1)) begin
                        byte_available <= 1'b1;
                        dout  <= oor ? 8'h00 : mem_q2;
                        cnt   <= '0;
                        idx   <= idx + 1'b1;
                        state <= RD_BYTES;
                    end
                end
                RD_BYTES: begin
                    if (cnt == CW'(BYTE_PERIOD - 1)) begin
                        byte_available <= 1'b1;
                        dout <= oor ? 8'h00 : mem_q2;
                        cnt  <= '0;
                        if (last_byte)
                            state <= TAIL;
                        else
                            idx <= idx + 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == CW'(CMD_LATENCY - 1)) begin
                        ready_for_next_byte <= 1'b1;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= WR_BYTES;
                    end
                end
                WR_BYTES: begin
                    if (at_din && last_byte) begin
                        idx   <= '0;
                        state <= WR_COMMIT;
                    end else begin
                        if (at_din)
                            idx <= idx + 1'b1;
                        if (cnt == CW'(BYTE_PERIOD - 1)) begin
                            ready_for_next_byte <= 1'b1;
                            cnt <= '0;
                        end
                    end
                end
                WR_COMMIT: begin
                    idx <= idx + 1'b1;
                    if (last_byte) begin
                        cnt   <= '0;
                        state <= TAIL;
                    end
                end
                TAIL: begin
                    if (cnt == CW'(TAIL_CYCLES)) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_store.sv
// Scoreboard bench for sd_sector_store: expected read bytes are queued at
// issue time and popped by a monitor on every byte_available pulse.
module tb_sd_sector_store;

    localparam int NS = 1024;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        ready;
    logic [31:0] address;
    logic        rd;
    logic [7:0]  dout;
    logic        byte_available;
    logic        wr;
    logic [7:0]  din;
    logic        ready_for_next_byte;
    logic        err_out;

    sd_sector_store dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .ready               (ready),
        .address             (address),
        .rd                  (rd),
        .dout                (dout),
        .byte_available      (byte_available),
        .wr                  (wr),
        .din                 (din),
        .ready_for_next_byte (ready_for_next_byte),
        .err_out             (err_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc++;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];
    int         pcyc[$];
    bit         prev_ba = 1'b0;
    bit   [7:0] model[int];
    logic [7:0] wr_buf[512];
    int         wcnt   = 0;
    int         wfirst = -1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_get(input int k);
        return model.exists(k) ? model[k] : 8'h00;
    endfunction

    // Monitor: every read pulse pops one expected byte.
    always @(negedge clk_in) begin
        if (byte_available === 1'b1) begin
            pcyc.push_back(cyc);
            if (prev_ba)
                check("ba_consecutive", 1, 0);
            if (exp_q.size() == 0)
                check("unexpected_byte", 1, 0);
            else
                check("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        end
        prev_ba = (byte_available === 1'b1);
    end

    // Write-data source: answers each ready_for_next_byte pulse.
    always @(negedge clk_in) begin
        if (ready_for_next_byte === 1'b1) begin
            if (wcnt == 0)
                wfirst = cyc;
            din = (wcnt < 512) ? wr_buf[wcnt] : 8'h00;
            wcnt++;
        end
    end

    task automatic issue(input logic [31:0] a, input bit r, input bit w,
                         output int t);
        int k = 0;
        @(negedge clk_in);
        while (ready !== 1'b1 && k < 10000) begin
            @(negedge clk_in);
            k++;
        end
        check("issue_ready", {31'd0, ready}, 1);
        address = a;
        rd      = r;
        wr      = w;
        t       = cyc;
        @(posedge clk_in);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, {31'd0, ready}, 0);
        check({tag, " ba"}, {31'd0, byte_available}, 0);
        check({tag, " rfnb"}, {31'd0, ready_for_next_byte}, 0);
        check({tag, " dout"}, {24'd0, dout}, 0);
        check({tag, " err"}, {31'd0, err_out}, 0);
    endtask

    task automatic release_and_init(input string tag);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (63) @(posedge clk_in);
        #1;
        check({tag, " init_low"}, {31'd0, ready}, 0);
        @(posedge clk_in);
        #1;
        check({tag, " init_high"}, {31'd0, ready}, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input bit both,
                           input bit toggle, input string tag);
        int sector;
        bit is_oor;
        int t;
        int k;
        int w0;
        int rc;
        sector = int'(a[31:9]);
        is_oor = sector >= NS;
        for (int i = 0; i < 512; i++)
            exp_q.push_back(is_oor ? 8'h00 : model_get(sector * 512 + i));
        pcyc.delete();
        w0 = wcnt;
        issue(a, 1'b1, both, t);
        k = 0;
        @(negedge clk_in);
        while (ready !== 1'b1 && k < 6000) begin
            if (toggle && (cyc - t) < 300) begin
                rd = cyc[0];
                wr = ~cyc[0];
            end else begin
                rd = 1'b0;
                wr = 1'b0;
            end
            @(negedge clk_in);
            k++;
        end
        rd = 1'b0;
        wr = 1'b0;
        rc = cyc;
        check({tag, " ready"}, {31'd0, ready}, 1);
        check({tag, " count"}, pcyc.size(), 512);
        check({tag, " leftover"}, exp_q.size(), 0);
        check({tag, " rfnb"}, wcnt - w0, 0);
        if (pcyc.size() == 512) begin
            check({tag, " first"}, pcyc[0], t + 17);
            check({tag, " last"}, pcyc[511], t + 17 + 511 * 8);
            check({tag, " tail"}, rc, pcyc[511] + 9);
        end
        exp_q.delete();
    endtask

    task automatic do_write(input logic [31:0] a, input int mul,
                            input int add, input string tag);
        int sector;
        bit is_oor;
        int t;
        int rc;
        sector = int'(a[31:9]);
        is_oor = sector >= NS;
        for (int i = 0; i < 512; i++) begin
            wr_buf[i] = 8'((i * mul + add) & 255);
            if (!is_oor)
                model[sector * 512 + i] = wr_buf[i];
        end
        wcnt   = 0;
        wfirst = -1;
        pcyc.delete();
        issue(a, 1'b0, 1'b1, t);
        @(negedge clk_in);
        begin
            int k = 0;
            while (ready !== 1'b1 && k < 8000) begin
                @(negedge clk_in);
                k++;
            end
        end
        rc = cyc;
        check({tag, " ready"}, {31'd0, ready}, 1);
        check({tag, " rfnb_count"}, wcnt, 512);
        check({tag, " rfnb_first"}, wfirst, t + 17);
        check({tag, " no_read_pulse"}, pcyc.size(), 0);
        check({tag, " busy_time"}, (rc - t) > 512 * 8 + 512, 1);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int k;
        int np;
        rst_n_in = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        din      = 8'h00;
        address  = 32'h0;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("por");
        release_and_init("por");

        do_write(32'h600, 1, 0, "wr3");
        do_read(32'h600, 1'b0, 1'b0, "rd3");
        do_read(32'hA00, 1'b0, 1'b0, "rd5");
        do_read(32'h6AB, 1'b0, 1'b1, "rd3_toggle");

        do_write(32'h0, 7, 1, "wr0");
        check("err_before_oor", {31'd0, err_out}, 0);
        do_read(32'h0, 1'b1, 1'b0, "rd0_both");

        do_write(NS * 512, 3, 85, "wr_oor");
        check("err_after_oor_wr", {31'd0, err_out}, 1);
        do_read(NS * 512, 1'b0, 1'b0, "rd_oor");
        do_read(32'h0, 1'b0, 1'b0, "rd0_after_oor");
        check("err_sticky", {31'd0, err_out}, 1);

        for (int i = 0; i < 512; i++)
            exp_q.push_back(model_get(3 * 512 + i));
        pcyc.delete();
        issue(32'h600, 1'b1, 1'b0, t);
        k = 0;
        while (pcyc.size() < 100 && k < 2000) begin
            @(negedge clk_in);
            k++;
        end
        check("mid_pulses", {31'd0, pcyc.size() >= 100}, 1);
        rst_n_in = 1'b0;
        #1;
        check_reset_outputs("mid");
        exp_q.delete();
        np = pcyc.size();
        repeat (20) @(negedge clk_in);
        check("mid_quiet", pcyc.size(), np);
        release_and_init("mid");
        do_read(32'h600, 1'b0, 1'b0, "rd3_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
